apb_slave_regfile: RTL and testbench

- APB-style completer (slave end) of the master/slave transactor interface (sel, en, addr, wr_en, wr_data, rd_data).
- Responds to master setup/access phases with a programmable number of wait states and returns read data from an internal register file.
- Flags out-of-range and misaligned accesses.
- Sits on the slave interface and serves as the DUT-side reference responder for transactor tests.

---
 rtl/apb_slave_regfile_if.sv | 31 +++
 rtl/apb_slave_regfile.sv | 173 +++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_regfile_if
//  Description : APB-style master/slave transfer bundle (select, enable,
//                address, direction, write data, read data, ready, error).
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              sel;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ready;
  logic              slv_err;

  modport master (
    output sel, en, addr, wr_en, wr_data,
    input  rd_data, ready, slv_err
  );

  modport slave (
    input  sel, en, addr, wr_en, wr_data,
    output rd_data, ready, slv_err
  );
endinterface
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_regfile
//  Description : APB-style completer with a word register file, a fixed
//                number of access-phase wait states and error reporting for
//                out-of-range or misaligned addresses. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  apb_slave_regfile_if.slave  bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Counter preload for the first wait cycle; unused when there are no waits.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RDY  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wr;
  logic [DATA_W-1:0] lat_wdata;

  logic              ready_q;
  logic              slv_err_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Decode helpers: from IDLE the transfer is being set up this very edge,
  // so the live bus fields are used; afterwards the latched copies are.
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_wr;
  logic [ADDR_W:0]   eff_word;
  logic [IDX_W-1:0]  eff_idx;
  logic              eff_err;

  logic              do_latch;
  logic              do_enter;
  logic              do_commit;
  logic              do_clear;

  assign eff_addr = (state == S_IDLE) ? bus.addr  : lat_addr;
  assign eff_wr   = (state == S_IDLE) ? bus.wr_en : lat_wr;
  assign eff_word = {1'b0, eff_addr} >> 2;
  assign eff_idx  = eff_addr[IDX_W+1:2];
  assign eff_err  = (eff_addr[1:0] != 2'b00) || (eff_word >= WORD_LIMIT);

  assign bus.ready   = ready_q;
  assign bus.slv_err = slv_err_q;
  assign bus.rd_data = rd_data_q;

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode and per-edge action strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_latch  = 1'b0;
    do_enter  = 1'b0;
    do_commit = 1'b0;
    do_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        // sel with en already high and no setup cycle is ignored.
        if (bus.sel && !bus.en) begin
          do_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RDY;
            do_enter  = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.sel) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_RDY;
          do_enter  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RDY: begin
        if (!bus.sel) begin
          state_nxt = S_IDLE;
          do_clear  = 1'b1;
        end else if (bus.en) begin
          state_nxt = S_IDLE;
          do_clear  = 1'b1;
          do_commit = lat_wr && !eff_err;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
        do_clear  = 1'b1;
      end
    endcase
  end

  // Capture the transfer fields at the setup edge; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
    end else if (do_latch) begin
      lat_addr  <= bus.addr;
      lat_wr    <= bus.wr_en;
      lat_wdata <= bus.wr_data;
    end
  end

  // Registered response: loaded on entry to RDY, cleared on completion or abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      slv_err_q <= 1'b0;
      rd_data_q <= '0;
    end else if (do_enter) begin
      ready_q   <= 1'b1;
      slv_err_q <= eff_err;
      rd_data_q <= (!eff_wr && !eff_err) ? regs[eff_idx] : '0;
    end else if (do_clear) begin
      ready_q   <= 1'b0;
      slv_err_q <= 1'b0;
      rd_data_q <= '0;
    end
  end

  // Register file: a write lands only on the completion edge of a good transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (do_commit) begin
      regs[eff_idx] <= lat_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_slave_regfile
//  Description : Directed bench for apb_slave_regfile with three instances
//                (0, 2 and 3 wait states) sharing one set of bus drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel_v;
  logic        bus_en;
  logic [7:0]  bus_addr;
  logic        bus_wr_en;
  logic [31:0] bus_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(32)) b0 ();
  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(32)) b2 ();
  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(32)) b3 ();

  assign b0.sel = sel_v[0];
  assign b2.sel = sel_v[1];
  assign b3.sel = sel_v[2];
  assign b0.en = bus_en;       assign b2.en = bus_en;       assign b3.en = bus_en;
  assign b0.addr = bus_addr;   assign b2.addr = bus_addr;   assign b3.addr = bus_addr;
  assign b0.wr_en = bus_wr_en; assign b2.wr_en = bus_wr_en; assign b3.wr_en = bus_wr_en;
  assign b0.wr_data = bus_wdata; assign b2.wr_data = bus_wdata; assign b3.wr_data = bus_wdata;

  apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  apb_slave_regfile #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  logic [2:0]  rdy_a;
  logic [2:0]  err_a;
  logic [31:0] rd_a [3];
  assign rdy_a = {b3.ready, b2.ready, b0.ready};
  assign err_a = {b3.slv_err, b2.slv_err, b0.slv_err};
  assign rd_a[0] = b0.rd_data;
  assign rd_a[1] = b2.rd_data;
  assign rd_a[2] = b3.rd_data;

  typedef struct {
    int          dut;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full transfer on instance i; entered and left just after a negedge so
  // a following call forms a back-to-back transfer.
  task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rdat, output bit e, output int waits,
                      output bit rdy_after, output bit tmo);
    sel_v     = '0;
    sel_v[i]  = 1'b1;
    bus_en    = 1'b0;
    bus_addr  = a;
    bus_wr_en = wr;
    bus_wdata = d;
    @(negedge clk);
    bus_en = 1'b1;
    waits  = 0;
    tmo    = 1'b0;
    while (!rdy_a[i]) begin
      if (waits >= 20) begin
        tmo = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    rdat = rd_a[i];
    e    = err_a[i];
    @(negedge clk);
    rdy_after = rdy_a[i];
    sel_v  = '0;
    bus_en = 1'b0;
  endtask

  task automatic run_check(input string nm, input vec_t v);
    logic [31:0] rdat;
    bit e, ra, tmo;
    int w;
    xfer(v.dut, v.wr, v.addr, v.wdata, rdat, e, w, ra, tmo);
    chk({nm, ".timeout"}, 32'(tmo), 32'd0);
    chk({nm, ".waits"},   32'(w), 32'(v.exp_waits));
    chk({nm, ".slv_err"}, 32'(e), 32'(v.exp_err));
    chk({nm, ".rd_data"}, rdat, v.exp_rd);
    chk({nm, ".pulse"},   32'(ra), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus and checking.
  initial begin
    rst_n     = 1'b0;
    sel_v     = '0;
    bus_en    = 1'b0;
    bus_addr  = '0;
    bus_wr_en = 1'b0;
    bus_wdata = '0;

    //          dut wr addr   wdata          exp_rd         err waits
    vt[0]  = '{0, 0, 8'h08, 32'h0,         32'h0,         0, 0};
    vt[1]  = '{0, 1, 8'h3C, 32'hDEADBEEF,  32'h0,         0, 0};
    vt[2]  = '{0, 0, 8'h3C, 32'h0,         32'hDEADBEEF,  0, 0};
    vt[3]  = '{0, 1, 8'h40, 32'hA5A5A5A5,  32'h0,         1, 0};
    vt[4]  = '{0, 1, 8'h06, 32'hA5A5A5A5,  32'h0,         1, 0};
    vt[5]  = '{0, 0, 8'h00, 32'h0,         32'h0,         0, 0};
    vt[6]  = '{0, 0, 8'h40, 32'h0,         32'h0,         1, 0};
    vt[7]  = '{2, 1, 8'h04, 32'h12345678,  32'h0,         0, 3};
    vt[8]  = '{2, 0, 8'h04, 32'h0,         32'h12345678,  0, 3};
    vt[9]  = '{0, 0, 8'h04, 32'h0,         32'h0,         0, 0};
    vt[10] = '{1, 1, 8'h08, 32'hCAFEF00D,  32'h0,         0, 2};
    vt[11] = '{1, 0, 8'h08, 32'h0,         32'hCAFEF00D,  0, 2};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.ready%0d", i),   32'(rdy_a[i]), 32'd0);
      chk($sformatf("reset.slv_err%0d", i), 32'(err_a[i]), 32'd0);
      chk($sformatf("reset.rd_data%0d", i), rd_a[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("vec%0d", i), vt[i]);
    end

    // Access phase without a setup cycle is ignored and writes nothing.
    sel_v = 3'b001; bus_en = 1'b1; bus_addr = 8'h3C; bus_wr_en = 1'b1; bus_wdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("nosetup.ready%0d", k), 32'(rdy_a[0]), 32'd0);
    end
    sel_v = '0; bus_en = 1'b0;
    @(negedge clk);
    run_check("nosetup.readback", '{0, 0, 8'h3C, 32'h0, 32'hDEADBEEF, 0, 0});

    // Bus fields changing after setup must not affect the transfer.
    sel_v = 3'b001; bus_en = 1'b0; bus_addr = 8'h3C; bus_wr_en = 1'b0; bus_wdata = 32'h0;
    @(negedge clk);
    bus_en = 1'b1; bus_addr = 8'h08; bus_wr_en = 1'b1; bus_wdata = 32'h11111111;
    chk("latch.ready",   32'(rdy_a[0]), 32'd1);
    chk("latch.rd_data", rd_a[0], 32'hDEADBEEF);
    @(negedge clk);
    sel_v = '0; bus_en = 1'b0;
    run_check("latch.noside", '{0, 0, 8'h08, 32'h0, 32'h0, 0, 0});

    // Drop sel during the wait states: abort, no write, no ready.
    sel_v = 3'b010; bus_en = 1'b0; bus_addr = 8'h10; bus_wr_en = 1'b1; bus_wdata = 32'h55;
    @(negedge clk);
    bus_en = 1'b1;
    @(negedge clk);
    chk("abort.wait_ready", 32'(rdy_a[1]), 32'd0);
    sel_v = '0; bus_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort.ready%0d", k), 32'(rdy_a[1]), 32'd0);
    end
    run_check("abort.readback", '{1, 0, 8'h10, 32'h0, 32'h0, 0, 2});

    // Reset pulse in the middle of a waited write.
    sel_v = 3'b010; bus_en = 1'b0; bus_addr = 8'h14; bus_wr_en = 1'b1; bus_wdata = 32'h77;
    @(negedge clk);
    bus_en = 1'b1;
    @(negedge clk);
    chk("rst.wait_ready", 32'(rdy_a[1]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.ready",   32'(rdy_a[1]), 32'd0);
    chk("rst.slv_err", 32'(err_a[1]), 32'd0);
    chk("rst.rd_data", rd_a[1], 32'd0);
    rst_n = 1'b1; sel_v = '0; bus_en = 1'b0;
    @(negedge clk);
    run_check("rst.readback", '{1, 0, 8'h14, 32'h0, 32'h0, 0, 2});
    run_check("rst.cleared",  '{0, 0, 8'h3C, 32'h0, 32'h0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
